// File: rtl/chip8_ram_arbiter.sv
// chip8_ram_arbiter
// Shares the single 4 KiB byte RAM port between two requesters: port A (CPU core)
// and port B (ROM loader / display scanout). One transaction is in flight at a time.
// Round-robin arbitration. Writes take one ACCESS cycle. Reads take READ_LATENCY
// ACCESS cycles. A single DONE cycle follows every transaction.
//
// Ports
//   clock, reset              : system clock; asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata : port A request; held stable until a_done
//   a_done, a_rdata           : port A completion pulse and read data
//   b_*                       : same set of signals for port B
//   ram_address_out, ram_data_out, ram_write : RAM command outputs
//   ram_data_in               : RAM read data, valid READ_LATENCY cycles after address
//   busy                      : high while the arbiter is not idle
module chip8_ram_arbiter #(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [11:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_done,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [11:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_done,
  output logic [7:0]  b_rdata,
  output logic [11:0] ram_address_out,
  output logic [7:0]  ram_data_out,
  output logic        ram_write,
  input  logic [7:0]  ram_data_in,
  output logic        busy
);

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Port identifiers for r_cur / r_prio
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_prio, w_prio_nxt;
  logic                r_cur, w_cur_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic                r_write, w_write_nxt;
  logic                r_a_done, w_a_done_nxt;
  logic                r_b_done, w_b_done_nxt;
  logic [DATA_W-1:0]   r_a_rdata, w_a_rdata_nxt;
  logic [DATA_W-1:0]   r_b_rdata, w_b_rdata_nxt;
  logic                r_busy, w_busy_nxt;

  // Requests eligible for a grant; the port just served is masked for the DONE edge
  logic w_a_elig, w_b_elig, w_pick_b, w_sel_we;

  always_comb begin
    w_a_elig = a_req && !((r_state == ST_DONE) && (r_cur == PORT_A));
    w_b_elig = b_req && !((r_state == ST_DONE) && (r_cur == PORT_B));
    // B wins if it is the only eligible requester, or both are and B holds priority
    w_pick_b = w_b_elig && (!w_a_elig || (r_prio == PORT_B));
    w_sel_we = w_pick_b ? b_we : a_we;
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_prio_nxt    = r_prio;
    w_cur_nxt     = r_cur;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_write_nxt   = r_write;
    w_a_done_nxt  = 1'b0;
    w_b_done_nxt  = 1'b0;
    w_a_rdata_nxt = r_a_rdata;
    w_b_rdata_nxt = r_b_rdata;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_a_elig || w_b_elig) begin
          w_state_nxt = ST_ACCESS;
          w_cur_nxt   = w_pick_b;
          w_addr_nxt  = w_pick_b ? b_addr : a_addr;
          w_write_nxt = w_sel_we;
          w_wdata_nxt = w_sel_we ? (w_pick_b ? b_wdata : a_wdata) : '0;
          w_cnt_nxt   = CNT_W'(READ_LATENCY - 1);
          // Priority only rotates when it actually resolved a contention
          if (w_a_elig && w_b_elig) begin
            w_prio_nxt = ~r_prio;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (r_write) begin
          // Write strobe lasts exactly one cycle
          w_write_nxt = 1'b0;
          w_wdata_nxt = '0;
          w_state_nxt = ST_DONE;
          if (r_cur == PORT_B) w_b_done_nxt = 1'b1;
          else                 w_a_done_nxt = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_DONE;
          if (r_cur == PORT_B) begin
            w_b_done_nxt  = 1'b1;
            w_b_rdata_nxt = ram_data_in;
          end else begin
            w_a_done_nxt  = 1'b1;
            w_a_rdata_nxt = ram_data_in;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_prio    <= PORT_A;
      r_cur     <= PORT_A;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_a_done  <= 1'b0;
      r_b_done  <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_prio    <= w_prio_nxt;
      r_cur     <= w_cur_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_write   <= w_write_nxt;
      r_a_done  <= w_a_done_nxt;
      r_b_done  <= w_b_done_nxt;
      r_a_rdata <= w_a_rdata_nxt;
      r_b_rdata <= w_b_rdata_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign ram_address_out = r_addr;
  assign ram_data_out    = r_wdata;
  assign ram_write       = r_write;
  assign a_done          = r_a_done;
  assign b_done          = r_b_done;
  assign a_rdata         = r_a_rdata;
  assign b_rdata         = r_b_rdata;
  assign busy            = r_busy;

endmodule

// File: tb/tb_chip8_ram_arbiter.sv
// Directed testbench for chip8_ram_arbiter with a small synchronous RAM model.
module tb_chip8_ram_arbiter;

  localparam int unsigned RL = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [11:0] a_addr = '0;
  logic [7:0]  a_wdata = '0;
  logic        a_done;
  logic [7:0]  a_rdata;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [11:0] b_addr = '0;
  logic [7:0]  b_wdata = '0;
  logic        b_done;
  logic [7:0]  b_rdata;
  logic [11:0] ram_address_out;
  logic [7:0]  ram_data_out;
  logic        ram_write;
  logic [7:0]  ram_data_in;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  chip8_ram_arbiter #(.READ_LATENCY(RL)) u_dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done), .b_rdata(b_rdata),
    .ram_address_out(ram_address_out), .ram_data_out(ram_data_out),
    .ram_write(ram_write), .ram_data_in(ram_data_in), .busy(busy)
  );

  always #5 clock = ~clock;

  // RAM model: one register stage, so data for an address presented at edge G
  // is on ram_data_in when the arbiter samples at edge G+2.
  logic [7:0] mem [4096];
  logic [7:0] r_q = '0;
  always @(posedge clock) begin
    if (ram_write) mem[ram_address_out] <= ram_data_out;
    r_q <= mem[ram_address_out];
  end
  assign ram_data_in = r_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_port(input bit pb, input bit req, input bit we,
                          input logic [11:0] addr, input logic [7:0] wd);
    if (pb) begin b_req = req; b_we = we; b_addr = addr; b_wdata = wd; end
    else    begin a_req = req; a_we = we; a_addr = addr; a_wdata = wd; end
  endtask

  task automatic do_write(input bit pb, input logic [11:0] addr, input logic [7:0] wd);
    set_port(pb, 1'b1, 1'b1, addr, wd);
    tick;
    check("wr_grant_we", 32'(ram_write), 32'd1);
    check("wr_grant_addr", 32'(ram_address_out), 32'(addr));
    check("wr_grant_data", 32'(ram_data_out), 32'(wd));
    tick;
    check("wr_we_drop", 32'(ram_write), 32'd0);
    check("wr_done", 32'(pb ? b_done : a_done), 32'd1);
    check("wr_data_zero", 32'(ram_data_out), 32'd0);
    set_port(pb, 1'b0, 1'b0, addr, wd);
    tick;
    check("wr_idle", 32'(busy), 32'd0);
    check("wr_mem", 32'(mem[addr]), 32'(wd));
  endtask

  initial begin
    // 1: reset held with a_req asserted, A write 0x200 <= 0x6A pending
    set_port(1'b0, 1'b1, 1'b1, 12'h200, 8'h6A);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("rst_we", 32'(ram_write), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_addr", 32'(ram_address_out), 32'd0);
      check("rst_done", 32'(a_done), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    // 2: grant edge, then one-cycle write strobe
    tick;
    check("t1_busy", 32'(busy), 32'd1);
    check("t2_we", 32'(ram_write), 32'd1);
    check("t2_addr", 32'(ram_address_out), 32'h200);
    check("t2_data", 32'(ram_data_out), 32'h6A);
    tick;
    check("t2_we_drop", 32'(ram_write), 32'd0);
    check("t2_done", 32'(a_done), 32'd1);
    check("t2_data_zero", 32'(ram_data_out), 32'd0);
    tick;
    // a_req still held across the DONE edge: must not be reissued
    check("t2_done_end", 32'(a_done), 32'd0);
    check("t2_no_reissue", 32'(busy), 32'd0);
    check("t2_addr_hold", 32'(ram_address_out), 32'h200);
    set_port(1'b0, 1'b0, 1'b0, 12'h200, 8'h00);
    tick;
    check("t2_idle", 32'(busy), 32'd0);
    check("t2_mem", 32'(mem[12'h200]), 32'h6A);

    // 3: A read 0x200
    set_port(1'b0, 1'b1, 1'b0, 12'h200, 8'h00);
    tick;
    check("t3_grant_addr", 32'(ram_address_out), 32'h200);
    check("t3_grant_we", 32'(ram_write), 32'd0);
    tick;
    check("t3_early_done", 32'(a_done), 32'd0);
    check("t3_b_done0", 32'(b_done), 32'd0);
    tick;
    check("t3_done", 32'(a_done), 32'd1);
    check("t3_rdata", 32'(a_rdata), 32'h6A);
    check("t3_b_done1", 32'(b_done), 32'd0);
    set_port(1'b0, 1'b0, 1'b0, 12'h200, 8'h00);
    tick;
    check("t3_done_end", 32'(a_done), 32'd0);
    check("t3_idle", 32'(busy), 32'd0);

    // Preload read data through both ports
    do_write(1'b0, 12'h300, 8'h11);
    do_write(1'b1, 12'h301, 8'h22);

    // 4: both ports reading continuously -> A,B,A,B
    set_port(1'b0, 1'b1, 1'b0, 12'h300, 8'h00);
    set_port(1'b1, 1'b1, 1'b0, 12'h301, 8'h00);
    for (int i = 0; i < 4; i++) begin
      bit exp_b;
      exp_b = (i % 2) == 1;
      tick;
      check("t4_grant_addr", 32'(ram_address_out), exp_b ? 32'h301 : 32'h300);
      check("t4_busy", 32'(busy), 32'd1);
      check("t4_no_done_a", 32'(a_done), 32'd0);
      check("t4_no_done_b", 32'(b_done), 32'd0);
      tick;
      tick;
      check("t4_a_done", 32'(a_done), exp_b ? 32'd0 : 32'd1);
      check("t4_b_done", 32'(b_done), exp_b ? 32'd1 : 32'd0);
      check("t4_rdata", exp_b ? 32'(b_rdata) : 32'(a_rdata), exp_b ? 32'h22 : 32'h11);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    tick;
    check("t4_idle", 32'(busy), 32'd0);

    // Contention from IDLE after one rotation: B now holds priority
    a_req = 1'b1;
    b_req = 1'b1;
    tick;
    check("prio_b_addr", 32'(ram_address_out), 32'h301);
    a_req = 1'b0;
    tick;
    tick;
    check("prio_b_done", 32'(b_done), 32'd1);
    check("prio_a_done", 32'(a_done), 32'd0);
    b_req = 1'b0;
    tick;
    check("prio_idle", 32'(busy), 32'd0);

    // 5: A read 0x301, req dropped and inputs changed after the grant
    set_port(1'b0, 1'b1, 1'b0, 12'h301, 8'h00);
    tick;
    check("t5_grant_addr", 32'(ram_address_out), 32'h301);
    set_port(1'b0, 1'b0, 1'b1, 12'h300, 8'hFF);
    tick;
    check("t5_no_write", 32'(ram_write), 32'd0);
    tick;
    check("t5_done", 32'(a_done), 32'd1);
    check("t5_rdata", 32'(a_rdata), 32'h22);
    tick;
    check("t5_done_end", 32'(a_done), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_mem_intact", 32'(mem[12'h300]), 32'h11);

    // 6: reset during the ACCESS of a B write
    set_port(1'b1, 1'b1, 1'b1, 12'h123, 8'h5C);
    tick;
    check("t6_grant_we", 32'(ram_write), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_we", 32'(ram_write), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_addr", 32'(ram_address_out), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick;
      check("t6_rst_no_done", 32'(b_done), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    tick;
    check("t6_regrant_we", 32'(ram_write), 32'd1);
    check("t6_regrant_addr", 32'(ram_address_out), 32'h123);
    check("t6_regrant_data", 32'(ram_data_out), 32'h5C);
    check("t6_regrant_busy", 32'(busy), 32'd1);
    tick;
    check("t6_done", 32'(b_done), 32'd1);
    b_req = 1'b0;
    tick;
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_mem", 32'(mem[12'h123]), 32'h5C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
